// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: PC step / index shift,
// queue entry layout and the fetch FSM encoding.
`timescale 1ns/1ps
package imem_fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    localparam int FAULT_W = 1;

    function automatic int step_bytes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int index_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Queue entry is {pc, data, fault} with pc in the most significant bits.
    function automatic int entry_width(input int addr_w, input int data_w);
        return addr_w + data_w + FAULT_W;
    endfunction

endpackage

// File: rtl/imem_fetch_unit_fetch_queue.sv
// Synchronous FIFO holding prefetched entries; flush empties it in one edge and
// wins over push/pop on that edge.
`timescale 1ns/1ps
module fetch_queue #(
    parameter int W      = 8,
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic                      head_valid,
    output logic [W-1:0]              head_data,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int PW = $clog2(QDEPTH);

    logic [W-1:0]  storage [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full       = (count == (PW+1)'(QDEPTH));
    assign head_valid = (count != '0);
    assign do_pop     = pop & head_valid & ~flush;
    assign do_push    = push & ~flush & (~full | do_pop);

    // NOTE: storage is deliberately not reset; head_data is gated by head_valid
    // so an empty queue always presents zero.
    always_ff @(posedge clk) begin
        if (do_push)
            storage[wr_ptr] <= push_data;
    end

    assign head_data = head_valid ? storage[rd_ptr] : '0;

    // NOTE: non-blocking assignments only, so every register here samples the
    // pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with autonomous sequential prefetch into a small queue,
// redirect flush, a load port and out-of-range fault tagging.
`timescale 1ns/1ps
module imem_fetch_unit
    import imem_fetch_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 256,
    parameter int QDEPTH   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam int                STEP       = step_bytes(DATA_W);
    localparam int                SHIFT      = index_shift(DATA_W);
    localparam int                EW         = entry_width(ADDR_W, DATA_W);
    localparam int                MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CW         = $clog2(QDEPTH) + 1;
    localparam logic [31:0]       DEPTH_U    = 32'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_idx;
    logic [ADDR_W-1:0] load_idx;
    logic [ADDR_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_data;
    logic              rd_fault;
    logic              inflight;
    logic              issue;
    logic              pop;
    logic              fetch_oor;
    logic              load_ok;
    logic [CW-1:0]     q_count;
    logic [EW-1:0]     push_entry;
    logic [EW-1:0]     head_entry;

    assign fetch_idx = fetch_pc >> SHIFT;
    assign load_idx  = load_addr >> SHIFT;
    assign fetch_oor = (32'(fetch_idx) >= DEPTH_U);
    assign load_ok   = load_en && (32'(load_idx) < DEPTH_U);
    assign pop       = instr_valid & instr_ready;

    // Credit check counts the read in flight, and a pop this cycle frees a slot.
    // NOTE: default assignment first so no path through this block leaves a latch.
    always_comb begin
        issue = 1'b0;
        if (state == FETCH && !rst && !redirect_valid)
            issue = ({1'b0, q_count} + (CW+1)'(inflight))
                  < ((CW+1)'(QDEPTH) + (CW+1)'(pop));
    end

    // Read-first: the fetch read samples mem before a same-edge load lands.
    always_ff @(posedge clk) begin
        if (load_ok)
            mem[load_idx[MEM_AW-1:0]] <= load_data;
        if (issue)
            rd_data <= mem[fetch_idx[MEM_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= ADDR_W'(RESET_PC);
            inflight <= 1'b0;
            rd_pc    <= '0;
            rd_fault <= 1'b0;
        end else if (redirect_valid) begin
            state    <= FETCH;
            fetch_pc <= redirect_pc & ALIGN_MASK;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(STEP);
                rd_pc    <= fetch_pc;
                rd_fault <= fetch_oor;
                if (fetch_oor)
                    state <= HALT;
            end
        end
    end

    // Fault entries never expose whatever the truncated index happened to read.
    assign push_entry = {rd_pc, rd_data & {DATA_W{~rd_fault}}, rd_fault};

    fetch_queue #(
        .W      (EW),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (inflight),
        .push_data  (push_entry),
        .pop        (pop),
        .head_valid (instr_valid),
        .head_data  (head_entry),
        .count      (q_count)
    );

    assign {instr_pc, instr_data, instr_fault} = head_entry;

endmodule
